// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSB digit first,
// registered carry chain, start/busy/done handshake and signed overflow.
module serial_digit_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] opa, opb, res, res_nx;
    logic             carry;
    logic [CW-1:0]    step;
    logic [DIGIT-1:0] da, db, ds;
    logic             dc;
    logic             last;

    assign da   = opa[step*DIGIT +: DIGIT];
    assign db   = opb[step*DIGIT +: DIGIT];
    assign last = (step == LAST);
    assign busy = (state == RUN);

    assign {dc, ds} = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry};

    always_comb begin
        res_nx = res;
        res_nx[step*DIGIT +: DIGIT] = ds;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            step     <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub | cin;
                        step  <= '0;
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    carry <= dc;
                    if (last) begin
                        sum  <= res_nx;
                        cout <= dc;
                        // carry into MSB recovered from the MSB sum bit
                        overflow <= da[DIGIT-1] ^ db[DIGIT-1]
                                  ^ ds[DIGIT-1] ^ dc;
                        done <= 1'b1;
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder: 8/2, 32/4 and 32/32 instances
// checked against a signed/unsigned integer reference model.
module tb_serial_digit_adder;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       cout8, ovf8, busy8, done8;

    logic        start32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, sum32, sum1;
    logic        cout32, ovf32, busy32, done32;
    logic        cout1, ovf1, busy1, done1;

    serial_digit_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .sum(sum8), .cout(cout8),
        .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_digit_adder #(.WIDTH(32), .DIGIT(4)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .sum(sum32), .cout(cout32),
        .overflow(ovf32), .busy(busy32), .done(done32)
    );

    serial_digit_adder #(.WIDTH(32), .DIGIT(32)) dut1 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .sum(sum1), .cout(cout1),
        .overflow(ovf1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int errors = 0;

    exp_t q8[$], q32[$], q1[$];
    exp_t e8, e32, e1, last8, last32, last1;
    int   cnt8 = 0, cnt32 = 0, cnt1 = 0;

    task automatic chk(string nm, longint unsigned got,
                       longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: unsigned sum/difference for result and carry, true
    // signed value range test for overflow.
    function automatic exp_t model(int w, longint unsigned x,
                                   longint unsigned y, bit c, bit s);
        exp_t r;
        longint unsigned m, u;
        longint sx, sy, t, half;
        m    = (64'd1 << w) - 1;
        half = longint'(64'd1 << (w - 1));
        sx   = (x >= longint'(half)) ? longint'(x) - 2 * half : longint'(x);
        sy   = (y >= longint'(half)) ? longint'(y) - 2 * half : longint'(y);
        if (s) begin
            u    = x - y;
            r.co = (x >= y);
            t    = sx - sy;
        end else begin
            u    = x + y + longint'(c);
            r.co = (u > m);
            t    = sx + sy + longint'(c);
        end
        r.s  = u & m;
        r.ov = (t > half - 1) || (t < -half);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            cnt8  = 0;
            last8 = '0;
        end else begin
            if (busy8) cnt8++;
            if (done8) begin
                chk("busy8_in_done", longint'(busy8), 0);
                if (q8.size() == 0) chk("done8_spurious", 1, 0);
                else begin
                    e8 = q8.pop_front();
                    chk("sum8", longint'(sum8), e8.s);
                    chk("cout8", longint'(cout8), longint'(e8.co));
                    chk("ovf8", longint'(ovf8), longint'(e8.ov));
                    chk("busy8_len", longint'(cnt8), 4);
                    last8 = e8;
                end
                cnt8 = 0;
            end else begin
                chk("hold8", {cout8, ovf8, sum8},
                    {last8.co, last8.ov, last8.s[7:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            cnt32  = 0;
            last32 = '0;
        end else begin
            if (busy32) cnt32++;
            if (done32) begin
                if (q32.size() == 0) chk("done32_spurious", 1, 0);
                else begin
                    e32 = q32.pop_front();
                    chk("sum32", longint'(sum32), e32.s);
                    chk("cout32", longint'(cout32), longint'(e32.co));
                    chk("ovf32", longint'(ovf32), longint'(e32.ov));
                    chk("busy32_len", longint'(cnt32), 8);
                    last32 = e32;
                end
                cnt32 = 0;
            end else begin
                chk("hold32", {cout32, ovf32, sum32},
                    {last32.co, last32.ov, last32.s[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            cnt1  = 0;
            last1 = '0;
        end else begin
            if (busy1) cnt1++;
            if (done1) begin
                if (q1.size() == 0) chk("done1_spurious", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    chk("sum1", longint'(sum1), e1.s);
                    chk("cout1", longint'(cout1), longint'(e1.co));
                    chk("ovf1", longint'(ovf1), longint'(e1.ov));
                    chk("busy1_len", longint'(cnt1), 1);
                    last1 = e1;
                end
                cnt1 = 0;
            end else begin
                chk("hold1", {cout1, ovf1, sum1},
                    {last1.co, last1.ov, last1.s[31:0]});
            end
        end
    end

    task automatic op8(logic [7:0] x, logic [7:0] y, logic c, logic s);
        int n = 0;
        @(negedge clk);
        while (busy8) begin
            n++;
            if (n > 50) begin
                chk("op8_idle_timeout", 1, 0);
                return;
            end
            @(negedge clk);
        end
        a8 = x; b8 = y; cin8 = c; sub8 = s; start8 = 1'b1;
        q8.push_back(model(8, x, y, c, s));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic op32(logic [31:0] x, logic [31:0] y, logic c, logic s);
        int n = 0;
        @(negedge clk);
        while (busy32 || busy1) begin
            n++;
            if (n > 50) begin
                chk("op32_idle_timeout", 1, 0);
                return;
            end
            @(negedge clk);
        end
        a32 = x; b32 = y; cin32 = c; sub32 = s; start32 = 1'b1;
        q32.push_back(model(32, x, y, c, s));
        q1.push_back(model(32, x, y, c, s));
        @(posedge clk);
        #1;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
    endtask

    task automatic rstchk(string nm);
        @(negedge clk);
        chk({nm, "_busy"}, longint'(busy8), 0);
        chk({nm, "_done"}, longint'(done8), 0);
        chk({nm, "_sum"}, longint'(sum8), 0);
        chk({nm, "_cout"}, longint'(cout8), 0);
        chk({nm, "_ovf"}, longint'(ovf8), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rstchk("reset");
        chk("reset_busy32", longint'(busy32), 0);
        chk("reset_sum1", longint'(sum1), 0);

        op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b1, 1'b0);
        op8(8'h10, 8'h20, 1'b1, 1'b1);
        op8(8'h80, 8'h01, 1'b0, 1'b1);

        // handshake: ignored start during busy, then back-to-back start
        op8(8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h40; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        op8(8'h0F, 8'h01, 1'b0, 1'b0);

        // abandon an operation with reset at the second RUN edge
        op8(8'hAA, 8'h00, 1'b0, 1'b0);
        op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(q8.pop_back());
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rstchk("midrst");
        repeat (8) @(negedge clk);
        op8(8'h01, 8'h01, 1'b0, 1'b0);

        op32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        op32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        op32(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        op32(32'h0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 12; i++)
            op32($urandom, $urandom, 1'($urandom), 1'($urandom));

        n = 0;
        while ((q8.size() + q32.size() + q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", longint'(q8.size() + q32.size() + q1.size()), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Multi-cycle, parametrised successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, starting at the LSB digit, using a registered carry chain.
- Serves area-constrained datapaths that trade latency for adder width.
- Uses a start/busy/done handshake, registered results and signed-overflow detection.

Parameters:
- WIDTH, 32, operand and result width; must be ≥2.
- DIGIT, 4, bits processed per clock; must be ≥1 and must divide WIDTH. NSTEP = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start; ignored when sub=1.
- sub  input  1  mode, captured on the accepted start. 0: a+b+cin. 1: a+~b+1.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  carry out of the MSB. In sub mode, 1 = no borrow.
- overflow  output  1  two's-complement overflow of the operation.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when sum/cout/overflow update.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal operand, carry and step registers are cleared.
  - rst has priority over every other input.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, RUN.
  - IDLE: busy=0. If start=1 at edge E0:
    - latch a, b (inverted when sub=1), and carry = sub ? 1 : cin;
    - clear the step counter; go to RUN; busy=1 from E0.
  - RUN: at each edge Ek (k=1..NSTEP), digit k-1 (bits [k*DIGIT-1 : (k-1)*DIGIT]) is added with the registered carry. The digit result goes to the internal result shift register; the carry register takes the digit's carry-out.
  - At E_NSTEP:
    - sum <= full internal result; cout <= final carry;
    - overflow <= carry into MSB XOR carry out of MSB;
    - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency:
  - busy is high for exactly NSTEP cycles.
  - done is asserted in the cycle after edge E_NSTEP.
  - sum/cout/overflow are valid from E_NSTEP onward.
  - With DIGIT=WIDTH, NSTEP=1 and the operation takes a single RUN cycle.
- Output stability:
  - sum, cout and overflow do not change during RUN; they hold the previous result.
  - They change only at completion or on reset.
- start while busy=1 is ignored; captured operands are unaffected.
- Back-to-back: start=1 in the cycle where done=1 (busy=0) is accepted. Throughput is one operation per NSTEP+1 cycles.
- Changes to a, b, cin and sub after capture have no effect.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- The step counter is ceil(log2(NSTEP)) bits wide, minimum 1, and never wraps past NSTEP-1.

Test Plan:
- Add with signed overflow. WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, cin=0, sub=0, start for 1 cycle.
  - busy high for 4 cycles, then done pulses 1 cycle.
  - sum=0x96, cout=0, overflow=1.
- Carry wrap. WIDTH=8, DIGIT=2: a=0xFF, b=0x01, cin=1, sub=0 → sum=0x01, cout=1, overflow=0.
- Subtract.
  - WIDTH=8, DIGIT=2: a=0x10, b=0x20, sub=1, cin=1 (ignored) → sum=0xF0, cout=0, overflow=0.
  - Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
- Handshake. Start op1 (0x01+0x02); pulse start with 0x40+0x40 during busy, which must be ignored.
  - First done shows sum=0x03.
  - Assert start with 0x0F+0x01 in the done cycle; it must be accepted.
  - Next done shows sum=0x10 after NSTEP further busy cycles.
- Reset mid-run. Start 0x5A+0x3C, then assert rst at the 2nd RUN edge.
  - busy=0, done=0, sum=0, cout=0, overflow=0; no done pulse follows.
  - A later start for 0x01+0x01 completes with sum=0x02.
- Defaults. WIDTH=32, DIGIT=4: a=0xFFFFFFFF, b=0, cin=1.
  - 8 busy cycles.
  - sum=0x00000000, cout=1, overflow=0.
  - Repeat with DIGIT=32: 1 busy cycle, same result.
